// File: rtl/common_pkg.sv
// Shared writeback-side types: the memory-stage Signals bundle, branch
// condition encoding and the writeback FSM state.
package Common;

    // flags = {N, Z, C, V}; C is carry-out of the compare subtract (1 = no borrow)
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        COND_AL  = 3'd0,
        COND_NV  = 3'd1,
        COND_EQ  = 3'd2,
        COND_NE  = 3'd3,
        COND_LT  = 3'd4,
        COND_GE  = 3'd5,
        COND_LTU = 3'd6,
        COND_GEU = 3'd7
    } cond_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        wback;
        logic [4:0]  wreg;
        logic        branch;
        logic [3:0]  flags;
        cond_e       cond;
        logic [32:0] wdata;
    } Signals;

    typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} wb_state_e;

    function automatic logic cond_taken(input cond_e cond, input logic [3:0] flags);
        logic t;
        case (cond)
            COND_AL:  t = 1'b1;
            COND_NV:  t = 1'b0;
            COND_EQ:  t = flags[FLAG_Z];
            COND_NE:  t = !flags[FLAG_Z];
            COND_LT:  t = flags[FLAG_N] != flags[FLAG_V];
            COND_GE:  t = flags[FLAG_N] == flags[FLAG_V];
            COND_LTU: t = !flags[FLAG_C];
            COND_GEU: t = flags[FLAG_C];
            default:  t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/writeback_stage_regfile_2r1w.sv
// 32x32 register file, two combinational read ports with write-through
// bypass, one write port; x0 reads 0 and ignores writes.
module regfile_2r1w (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);

    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rd1 = regs[ra1];
        if (ra1 == 5'd0)                rd1 = '0;
        else if (we && waddr == ra1)    rd1 = wdata;
        rd2 = regs[ra2];
        if (ra2 == 5'd0)                rd2 = '0;
        else if (we && waddr == ra2)    rd2 = wdata;
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits register writes, turns taken branches into a
// one-cycle fetch redirect, squashes wrong-path work and counts retirements.
module writeback_stage
    import Common::*;
#(
    parameter int FLUSH_DEPTH = 3,
    parameter int CNT_W       = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  Signals           i_signals,
    input  logic             i_valid,
    input  logic [4:0]       rs1_addr,
    input  logic [4:0]       rs2_addr,
    output logic [31:0]      rs1_data,
    output logic [31:0]      rs2_data,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             flushing,
    output logic [CNT_W-1:0] retired
);

    localparam int CW = (FLUSH_DEPTH < 2) ? 1 : $clog2(FLUSH_DEPTH + 1);

    wb_state_e   state;
    logic [CW-1:0] cnt;
    logic        commit, taken, we;

    // pc and the spare wdata bit are carried for debug only
    logic unused_bits;
    assign unused_bits = ^{i_signals.pc, i_signals.wdata[32]};

    assign commit   = i_valid && state == RUN;
    assign taken    = commit && i_signals.branch && cond_taken(i_signals.cond, i_signals.flags);
    assign we       = commit && i_signals.wback;
    assign flushing = state == FLUSH;

    regfile_2r1w u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (i_signals.wreg),
        .wdata (i_signals.wdata[31:0]),
        .ra1   (rs1_addr),
        .ra2   (rs2_addr),
        .rd1   (rs1_data),
        .rd2   (rs2_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            cnt         <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
            retired     <= '0;
        end else begin
            redirect <= taken;
            if (taken) redirect_pc <= i_signals.wdata[31:0];
            if (commit) retired <= retired + CNT_W'(1);
            case (state)
                RUN: begin
                    if (taken && FLUSH_DEPTH != 0) begin
                        state <= FLUSH;
                        cnt   <= CW'(FLUSH_DEPTH);
                    end
                end
                FLUSH: begin
                    // bubbles carry no wrong-path work, so only valid slots count down
                    if (i_valid) begin
                        if (cnt == CW'(1)) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage (FLUSH_DEPTH=3, CNT_W=64).
module tb_writeback_stage;
    import Common::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    Signals      sig;
    logic        valid;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flushing;
    logic [63:0] retired;

    int checks = 0;
    int errors = 0;

    writeback_stage #(.FLUSH_DEPTH(3), .CNT_W(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_signals   (sig),
        .i_valid     (valid),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .flushing    (flushing),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; comb outputs sampled 1 time unit later.
    task automatic drive(input logic v, input logic wb, input logic [4:0] wr,
                         input logic br, input cond_e c, input logic [3:0] fl,
                         input logic [32:0] wd);
        @(negedge clk);
        valid        = v;
        sig.pc       = 32'h100;
        sig.wback    = wb;
        sig.wreg     = wr;
        sig.branch   = br;
        sig.cond     = c;
        sig.flags    = fl;
        sig.wdata    = wd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 5'd0, 1'b0, COND_NV, 4'h0, 33'h0);
    endtask

    task automatic test_reset();
        rs1_addr = 5'd3; rs2_addr = 5'd4;
        valid = 1'b0; sig = '0;
        #12;
        checks++; if (rs1_data !== 32'h0)  begin errors++; $display("FAIL reset_rs1 got %h want 0", rs1_data); end
        checks++; if (redirect !== 1'b0)   begin errors++; $display("FAIL reset_redirect got %b want 0", redirect); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got %h want 0", redirect_pc); end
        checks++; if (flushing !== 1'b0)   begin errors++; $display("FAIL reset_flushing got %b want 0", flushing); end
        checks++; if (retired !== 64'd0)   begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_bypass();
        rs1_addr = 5'd5; rs2_addr = 5'd5;
        drive(1'b1, 1'b1, 5'd5, 1'b0, COND_NV, 4'h0, {1'b1, 32'hDEADBEEF});
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs1 got %h want deadbeef", rs1_data); end
        checks++; if (rs2_data !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_rs2 got %h want deadbeef", rs2_data); end
        idle();
        checks++; if (rs1_data !== 32'hDEADBEEF) begin errors++; $display("FAIL array_rs1 got %h want deadbeef", rs1_data); end
        checks++; if (retired !== 64'd1) begin errors++; $display("FAIL bypass_retired got %0d want 1", retired); end
    endtask

    task automatic test_x0();
        rs1_addr = 5'd0;
        drive(1'b1, 1'b1, 5'd0, 1'b0, COND_NV, 4'h0, 33'h1234);
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_same got %h want 0", rs1_data); end
        idle();
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL x0_next got %h want 0", rs1_data); end
        checks++; if (retired !== 64'd2) begin errors++; $display("FAIL x0_retired got %0d want 2", retired); end
    endtask

    task automatic test_branch();
        rs1_addr = 5'd7;
        drive(1'b1, 1'b0, 5'd0, 1'b1, COND_AL, 4'h0, 33'h40);
        idle();
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL br_redirect got %b want 1", redirect); end
        checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL br_redirect_pc got %h want 40", redirect_pc); end
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL br_flushing got %b want 1", flushing); end
        checks++; if (retired !== 64'd3) begin errors++; $display("FAIL br_retired got %0d want 3", retired); end
        // three wrong-path writes to x7; the middle one is also a taken branch
        drive(1'b1, 1'b1, 5'd7, 1'b0, COND_NV, 4'h0, 33'h77);
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL sq_bypass got %h want 0", rs1_data); end
        drive(1'b1, 1'b1, 5'd7, 1'b1, COND_AL, 4'h0, 33'h999);
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL sq_redirect_pulse got %b want 0", redirect); end
        drive(1'b1, 1'b1, 5'd7, 1'b0, COND_NV, 4'h0, 33'h77);
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL sq_branch_redirect got %b want 0", redirect); end
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL sq_flushing got %b want 1", flushing); end
        drive(1'b1, 1'b1, 5'd7, 1'b0, COND_NV, 4'h0, 33'h77);
        checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL post_flushing got %b want 0", flushing); end
        checks++; if (retired !== 64'd3) begin errors++; $display("FAIL sq_retired got %0d want 3", retired); end
        checks++; if (redirect_pc !== 32'h40) begin errors++; $display("FAIL sq_redirect_pc got %h want 40", redirect_pc); end
        checks++; if (rs1_data !== 32'h77) begin errors++; $display("FAIL fourth_bypass got %h want 77", rs1_data); end
        idle();
        checks++; if (rs1_data !== 32'h77) begin errors++; $display("FAIL fourth_array got %h want 77", rs1_data); end
        checks++; if (retired !== 64'd4) begin errors++; $display("FAIL fourth_retired got %0d want 4", retired); end
    endtask

    task automatic test_bubbles();
        rs1_addr = 5'd8; rs2_addr = 5'd1;
        // taken EQ (Z=1) branch that also links into x1
        drive(1'b1, 1'b1, 5'd1, 1'b1, COND_EQ, 4'b0100, 33'h80);
        idle();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h80) begin errors++; $display("FAIL bub_redirect got %b/%h want 1/80", redirect, redirect_pc); end
        checks++; if (rs2_data !== 32'h80) begin errors++; $display("FAIL bub_link got %h want 80", rs2_data); end
        drive(1'b1, 1'b1, 5'd8, 1'b0, COND_NV, 4'h0, 33'h11);
        idle();
        idle();
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL bub_flush1 got %b want 1", flushing); end
        drive(1'b1, 1'b1, 5'd8, 1'b0, COND_NV, 4'h0, 33'h22);
        idle();
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL bub_flush2 got %b want 1", flushing); end
        drive(1'b1, 1'b1, 5'd8, 1'b0, COND_NV, 4'h0, 33'h33);
        idle();
        checks++; if (flushing !== 1'b0) begin errors++; $display("FAIL bub_done got %b want 0", flushing); end
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL bub_x8 got %h want 0", rs1_data); end
        checks++; if (retired !== 64'd5) begin errors++; $display("FAIL bub_retired got %0d want 5", retired); end
        drive(1'b1, 1'b1, 5'd8, 1'b0, COND_NV, 4'h0, 33'h88);
        idle();
        checks++; if (rs1_data !== 32'h88 || retired !== 64'd6) begin errors++; $display("FAIL bub_commit got %h/%0d want 88/6", rs1_data, retired); end
    endtask

    task automatic test_not_taken();
        drive(1'b1, 1'b0, 5'd0, 1'b1, COND_NV, 4'h0, 33'h200);
        idle();
        checks++; if (redirect !== 1'b0 || flushing !== 1'b0) begin errors++; $display("FAIL nt_nv got %b/%b want 0/0", redirect, flushing); end
        checks++; if (retired !== 64'd7) begin errors++; $display("FAIL nt_retired got %0d want 7", retired); end
        checks++; if (redirect_pc !== 32'h80) begin errors++; $display("FAIL nt_pc_hold got %h want 80", redirect_pc); end
        drive(1'b1, 1'b0, 5'd0, 1'b1, COND_EQ, 4'b0000, 33'h204);
        idle();
        checks++; if (redirect !== 1'b0 || flushing !== 1'b0 || retired !== 64'd8) begin errors++; $display("FAIL nt_eq got %b/%b/%0d want 0/0/8", redirect, flushing, retired); end
    endtask

    task automatic test_reset_mid_flush();
        rs1_addr = 5'd5; rs2_addr = 5'd9;
        drive(1'b1, 1'b0, 5'd0, 1'b1, COND_AL, 4'h0, 33'h300);
        drive(1'b1, 1'b1, 5'd7, 1'b0, COND_NV, 4'h0, 33'h55);
        checks++; if (flushing !== 1'b1) begin errors++; $display("FAIL rmf_flushing got %b want 1", flushing); end
        @(negedge clk);
        valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++; if (redirect !== 1'b0 || flushing !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rmf_outs got %b/%b/%h want 0/0/0", redirect, flushing, redirect_pc); end
        checks++; if (retired !== 64'd0) begin errors++; $display("FAIL rmf_retired got %0d want 0", retired); end
        checks++; if (rs1_data !== 32'h0) begin errors++; $display("FAIL rmf_regs got %h want 0", rs1_data); end
        @(negedge clk); rst = 1'b1;
        drive(1'b1, 1'b1, 5'd9, 1'b0, COND_NV, 4'h0, 33'h99);
        checks++; if (rs2_data !== 32'h99) begin errors++; $display("FAIL rmf_bypass got %h want 99", rs2_data); end
        idle();
        checks++; if (rs2_data !== 32'h99 || retired !== 64'd1 || flushing !== 1'b0) begin errors++; $display("FAIL rmf_commit got %h/%0d/%b want 99/1/0", rs2_data, retired, flushing); end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_branch();
        test_bubbles();
        test_not_taken();
        test_reset_mid_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
